// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selector and level-width helper used by
// the synchronous FIFO and reusable by the clock-crossing variant.
package fifo_pkg;

   typedef enum logic {
      FIFO_MODE_REG  = 1'b0,
      FIFO_MODE_FWFT = 1'b1
   } fifo_mode_e;

   // Level counter needs one extra bit so a full FIFO is distinguishable from empty.
   function automatic int fifo_lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) r_mem[waddr_i] <= wdata_i;
   end

   assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty,
// overflow/underflow pulses, synchronous flush and FWFT or registered read data.
module fifo_sync_lvl
   import fifo_pkg::*;
#(
   parameter int         FIFO_DEPTH = 16,
   parameter int         DATA_WIDTH = 32,
   parameter int         AFULL_THR  = FIFO_DEPTH - 2,
   parameter int         AEMPTY_THR = 2,
   parameter fifo_mode_e FWFT       = FIFO_MODE_FWFT
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        flush_i,
   input  logic                        we_i,
   input  logic [DATA_WIDTH-1:0]       wdata_i,
   output logic                        full_o,
   output logic                        afull_o,
   output logic                        overflow_o,
   input  logic                        re_i,
   output logic [DATA_WIDTH-1:0]       rdata_o,
   output logic                        rvalid_o,
   output logic                        empty_o,
   output logic                        aempty_o,
   output logic                        underflow_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = fifo_lvl_width(FIFO_DEPTH);
   localparam logic [LW-1:0] DEPTH_LVL  = LW'(FIFO_DEPTH);
   localparam logic [LW-1:0] AFULL_LVL  = LW'(AFULL_THR);
   localparam logic [LW-1:0] AEMPTY_LVL = LW'(AEMPTY_THR);

   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("fifo_sync_lvl: FIFO_DEPTH must be a power of two >= 2");
   end
   if ((AFULL_THR < 1) || (AFULL_THR > FIFO_DEPTH)) begin : g_chk_afull
      $error("fifo_sync_lvl: AFULL_THR out of range 1..FIFO_DEPTH");
   end
   if ((AEMPTY_THR < 0) || (AEMPTY_THR > FIFO_DEPTH - 1)) begin : g_chk_aempty
      $error("fifo_sync_lvl: AEMPTY_THR out of range 0..FIFO_DEPTH-1");
   end

   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [LW-1:0]         r_level;
   logic                  r_ovf;
   logic                  r_unf;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_full  = (r_level == DEPTH_LVL);
   assign w_empty = (r_level == '0);

   // Flush wins over both requests, so it also blocks the storage write.
   assign w_wr_acc = we_i & ~w_full  & ~flush_i;
   assign w_rd_acc = re_i & ~w_empty & ~flush_i;

   fifo_mem #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (w_wr_acc),
      .waddr_i (r_wptr),
      .wdata_i (wdata_i),
      .raddr_i (r_rptr),
      .rdata_o (w_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (flush_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_ovf <= we_i & w_full;
         r_unf <= re_i & w_empty;
         if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
         if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rdata_o  = w_rdata;
      assign rvalid_o = ~w_empty;
   end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_rdata;
      logic                  r_rvalid;

      // Read data holds its last value; only rvalid drops when idle or flushed.
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
         end else if (flush_i) begin
            r_rvalid <= 1'b0;
         end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) r_rdata <= w_rdata;
         end
      end

      assign rdata_o  = r_rdata;
      assign rvalid_o = r_rvalid;
   end

   assign full_o      = w_full;
   assign empty_o     = w_empty;
   assign afull_o     = (r_level >= AFULL_LVL);
   assign aempty_o    = (r_level <= AEMPTY_LVL);
   assign overflow_o  = r_ovf;
   assign underflow_o = r_unf;
   assign level_o     = r_level;

`ifdef FORMAL
   a_level_ptrs: assert property (@(posedge clk_i) disable iff (rst_i)
      (AW'(r_wptr - r_rptr) == r_level[AW-1:0]) && (r_level <= DEPTH_LVL));
   a_full_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      !(w_full && w_empty));
   c_full:     cover property (@(posedge clk_i) w_full);
   c_afull:    cover property (@(posedge clk_i) afull_o);
   c_aempty:   cover property (@(posedge clk_i) aempty_o && !w_empty);
   c_overflow: cover property (@(posedge clk_i) r_ovf);
`endif

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Randomised bench: one FWFT and one registered-read FIFO driven in lockstep
// and compared against a queue-based reference model.
module tb_fifo_sync_lvl;
   import fifo_pkg::*;

   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i, flush_i, we_i, re_i;
   logic [DW-1:0] wdata_i;

   logic          full_f, afull_f, ovf_f, empty_f, aempty_f, unf_f, rvalid_f;
   logic [DW-1:0] rdata_f;
   logic [4:0]    level_f;
   logic          full_r, afull_r, ovf_r, empty_r, aempty_r, unf_r, rvalid_r;
   logic [DW-1:0] rdata_r;
   logic [4:0]    level_r;
   logic [21:0]   stat;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] q[$];
   logic          m_ovf, m_unf, m_rv;
   logic [DW-1:0] m_rd;

   always #5 clk_i = ~clk_i;

   fifo_sync_lvl dut_f (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .we_i(we_i), .wdata_i(wdata_i),
      .full_o(full_f), .afull_o(afull_f), .overflow_o(ovf_f), .re_i(re_i),
      .rdata_o(rdata_f), .rvalid_o(rvalid_f), .empty_o(empty_f), .aempty_o(aempty_f),
      .underflow_o(unf_f), .level_o(level_f)
   );

   fifo_sync_lvl #(.FWFT(FIFO_MODE_REG)) dut_r (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .we_i(we_i), .wdata_i(wdata_i),
      .full_o(full_r), .afull_o(afull_r), .overflow_o(ovf_r), .re_i(re_i),
      .rdata_o(rdata_r), .rvalid_o(rvalid_r), .empty_o(empty_r), .aempty_o(aempty_r),
      .underflow_o(unf_r), .level_o(level_r)
   );

   assign stat = {full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f, level_f,
                  full_r, afull_r, empty_r, aempty_r, ovf_r, unf_r, level_r};

   // Expected flags for both instances, straight from the queue occupancy.
   function automatic logic [21:0] exp_stat();
      int n;
      logic [10:0] s;
      n = q.size();
      s = {n == 16, n >= 14, n == 0, n <= 2, m_ovf, m_unf, 5'(n)};
      return {s, s};
   endfunction

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
   endtask

   task automatic tick(input logic we, input logic [DW-1:0] wd, input logic re, input logic fl);
      we_i = we; wdata_i = wd; re_i = re; flush_i = fl;
      @(posedge clk_i);
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         m_rv  = 1'b0;
      end else begin
         m_ovf = we && (q.size() == 16);
         m_unf = re && (q.size() == 0);
         m_rv  = re && (q.size() > 0);
         if (m_rv) m_rd = q.pop_front();
         if (we && !m_ovf) q.push_back(wd);
      end
      #1;
      we_i = 1'b0; re_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; flush_i = 1'b0; we_i = 1'b0; re_i = 1'b0; wdata_i = '0;
      model_reset();
      @(posedge clk_i); #1;
      total++;
      if (stat !== exp_stat()) begin
         bad++; $display("FAIL reset_stat got=%h exp=%h", stat, exp_stat());
      end
      total++;
      if ({rvalid_f, rvalid_r, rdata_r} !== {2'b00, 32'h0}) begin
         bad++; $display("FAIL reset_rd got=%b %b %h exp=0 0 0", rvalid_f, rvalid_r, rdata_r);
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         tick(1'b1, DW'(i), 1'b0, 1'b0);
         total++;
         if (stat !== exp_stat()) begin
            bad++; $display("FAIL fill_stat i=%0d got=%h exp=%h", i, stat, exp_stat());
         end
         total++;
         if (rdata_f !== 32'h0) begin
            bad++; $display("FAIL fill_head i=%0d got=%h exp=0", i, rdata_f);
         end
      end
   endtask

   task automatic test_overflow();
      tick(1'b1, 32'hDEAD, 1'b0, 1'b0);
      total++;
      if (stat !== exp_stat() || !ovf_f || level_f !== 5'd16) begin
         bad++; $display("FAIL ovf_pulse got=%h exp=%h", stat, exp_stat());
      end
      tick(1'b0, '0, 1'b0, 1'b0);
      total++;
      if (stat !== exp_stat()) begin
         bad++; $display("FAIL ovf_clear got=%h exp=%h", stat, exp_stat());
      end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (rdata_f !== DW'(i)) begin
            bad++; $display("FAIL drain_fwft i=%0d got=%h exp=%h", i, rdata_f, DW'(i));
         end
         tick(1'b0, '0, 1'b1, 1'b0);
         total++;
         if (rvalid_r !== 1'b1 || rdata_r !== DW'(i)) begin
            bad++; $display("FAIL drain_reg i=%0d got=%b/%h exp=1/%h", i, rvalid_r, rdata_r, DW'(i));
         end
      end
      total++;
      if (stat !== exp_stat() || !empty_f) begin
         bad++; $display("FAIL drain_empty got=%h exp=%h", stat, exp_stat());
      end
   endtask

   task automatic test_underflow();
      tick(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (stat !== exp_stat() || !unf_r) begin
         bad++; $display("FAIL unf_pulse got=%h exp=%h", stat, exp_stat());
      end
      tick(1'b0, '0, 1'b0, 1'b0);
      total++;
      if (stat !== exp_stat()) begin
         bad++; $display("FAIL unf_clear got=%h exp=%h", stat, exp_stat());
      end
      tick(1'b1, 32'hA5, 1'b0, 1'b0);
      total++;
      if (rvalid_f !== 1'b1 || rdata_f !== 32'hA5) begin
         bad++; $display("FAIL unf_fwft got=%b/%h exp=1/a5", rvalid_f, rdata_f);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (rvalid_r !== 1'b1 || rdata_r !== 32'hA5) begin
         bad++; $display("FAIL unf_reg got=%b/%h exp=1/a5", rvalid_r, rdata_r);
      end
   endtask

   task automatic test_reg_mode();
      logic [DW-1:0] exp_d [3];
      logic          exp_v [3];
      exp_d = '{32'h11, 32'h22, 32'h22};
      exp_v = '{1'b1, 1'b1, 1'b0};
      tick(1'b1, 32'h11, 1'b0, 1'b0);
      tick(1'b1, 32'h22, 1'b0, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick(1'b0, '0, c < 2, 1'b0);
         total++;
         if (rvalid_r !== exp_v[c] || rdata_r !== exp_d[c]) begin
            bad++; $display("FAIL reg_mode c=%0d got=%b/%h exp=%b/%h", c, rvalid_r, rdata_r, exp_v[c], exp_d[c]);
         end
      end
   endtask

   task automatic test_flush();
      logic [DW-1:0] v;
      for (int i = 0; i < 8; i++) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
      total++;
      if (stat !== exp_stat() || level_f !== 5'd8) begin
         bad++; $display("FAIL flush_pre got=%h exp=%h", stat, exp_stat());
      end
      tick(1'b1, 32'hBAD0, 1'b1, 1'b1);
      total++;
      if (stat !== exp_stat() || !empty_f || !aempty_f || rvalid_r !== 1'b0) begin
         bad++; $display("FAIL flush_stat got=%h/%b exp=%h/0", stat, rvalid_r, exp_stat());
      end
      v = DW'($urandom);
      tick(1'b1, v, 1'b0, 1'b0);
      total++;
      if (rdata_f !== v) begin
         bad++; $display("FAIL flush_fwft got=%h exp=%h", rdata_f, v);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (rvalid_r !== 1'b1 || rdata_r !== v) begin
         bad++; $display("FAIL flush_reg got=%b/%h exp=1/%h", rvalid_r, rdata_r, v);
      end
   endtask

   task automatic test_stream();
      while (q.size() < 16) tick(1'b1, DW'($urandom), 1'b0, 1'b0);
      for (int k = 0; k < 40; k++) begin
         tick(($urandom % 8) != 0, DW'($urandom), ($urandom % 8) != 0, 1'b0);
         total++;
         if (stat !== exp_stat() || level_f > 5'd16) begin
            bad++; $display("FAIL stream_stat k=%0d got=%h exp=%h", k, stat, exp_stat());
         end
         total++;
         if (rvalid_f !== (q.size() > 0) || (q.size() > 0 && rdata_f !== q[0])) begin
            bad++; $display("FAIL stream_fwft k=%0d got=%b/%h", k, rvalid_f, rdata_f);
         end
         total++;
         if (rvalid_r !== m_rv || (m_rv && rdata_r !== m_rd)) begin
            bad++; $display("FAIL stream_reg k=%0d got=%b/%h exp=%b/%h", k, rvalid_r, rdata_r, m_rv, m_rd);
         end
         if (k == 20) begin
            rst_i = 1'b1;
            model_reset();
            #1;
            total++;
            if (stat !== exp_stat() || {rvalid_f, rvalid_r, rdata_r} !== {2'b00, 32'h0}) begin
               bad++; $display("FAIL async_rst got=%h/%b%b/%h exp=%h/00/0", stat, rvalid_f, rvalid_r, rdata_r, exp_stat());
            end
            @(posedge clk_i); #1;
            rst_i = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_underflow();
      test_reg_mode();
      test_flush();
      test_stream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
